mdu_ctrl: RTL and testbench
===========================

# mdu_ctrl

Multi-cycle multiply/divide sequencer for the E stage of the five-stage MIPS pipeline. It accepts mult/multu/div/divu/mthi/mtlo/mfhi/mflo from E, owns the architectural HI/LO registers, and runs a cycle counter that models the fixed MDU latency. It also drives the `busy` flag that the hazard/stall logic combines with `start` to freeze the pipeline for MDU-dependent instructions. A flush request (exception/interrupt) in the same cycle suppresses any start or HI/LO write.

## Interface
Parameters:
- MULT_CYCLES, 5, busy duration of mult/multu (≥1)
- DIV_CYCLES, 10, busy duration of div/divu (≥1)

Ports:
- clk  in  1  pipeline clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- start  in  1  E-stage instruction is an MDU op this cycle
- mdu_op  in  4  operation code, encodings from shared package
- A  in  32  rs operand (forwarded)
- B  in  32  rt operand (forwarded)
- req  in  1  exception/interrupt flush this cycle; blocks start and mt writes
- busy  out  1  multi-cycle operation in flight
- HI  out  32  architectural HI
- LO  out  32  architectural LO
- mdu_out  in→out  32  mfhi→HI, mflo→LO, otherwise 0 (combinational)

## Operation
- States: IDLE (busy=0, counter=0) and RUN (busy=1, counter>0).
- IDLE, edge with start & !req:
  - MULT/MULTU/DIV/DIVU: latch the 64-bit result into hidden temp_hi/temp_lo; counter←MULT_CYCLES or DIV_CYCLES; busy←1.
  - MTHI: HI←A. MTLO: LO←A. Single edge, busy stays 0.
  - MFHI/MFLO/NONE: no state change.
- RUN: each edge decrements counter. The edge where counter==1 writes HI←temp_hi and LO←temp_lo, counter←0, busy←0.
- start while busy=1: ignored, no latch and no restart. The stall logic is responsible for never issuing it.
- req with start: the op is dropped entirely, including mthi/mtlo.
- req during RUN: does not cancel the in-flight op, because it belongs to an already-committed older instruction.
- Arithmetic:
  - mult: signed 32×32→64, {HI,LO}. multu: unsigned.
  - div: LO=quotient truncated toward zero, HI=remainder with the sign of the dividend. divu: unsigned.
  - 0x80000000 / 0xFFFFFFFF (signed): LO=0x80000000, HI=0.
  - Divide by zero (B==0): full DIV_CYCLES busy, then HI/LO left unchanged.
- mdu_out reads HI/LO directly with no bypass from temp registers.

## Timing
- Reset (asynchronous): busy=0, HI=0, LO=0, counter=0, temp regs=0; mdu_out=0 unless mdu_op is MFHI/MFLO.
- start sampled at the end of cycle t:
  - busy is high for cycles t+1 … t+N exactly, where N = MULT_CYCLES or DIV_CYCLES.
  - New HI/LO are visible from cycle t+N+1, the same cycle busy falls.
- Back-to-back: a new start may be sampled in cycle t+N+1 and launches normally.
- MTHI/MTLO sampled at the end of cycle t: the new value is visible in cycle t+1.
- Reset asserted mid-RUN aborts immediately: busy=0 and HI/LO=0 with no completion write.

## Structure
- Shared package (mdu_pkg), operation encodings: MDU_NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MFHI=5, MFLO=6, MTHI=7, MTLO=8.
- Shared package also holds the default cycle-count constants.
- One combinational sub-module, mdu_arith (A, B, op → hi, lo, div_zero), keeps the signed/unsigned product and quotient logic out of the sequencer.
- The counter width is derived from the larger of the two cycle parameters.

## Test plan
- mult A=0xFFFFFFFE (−2), B=3, start at cycle 0 → busy=1 in cycles 1–5; in cycle 6 busy=0, HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- divu A=100, B=7 → busy high for 10 cycles, then LO=14, HI=2; signed div A=−7, B=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- mthi A=0x12345678 with req=1 → HI unchanged; repeat with req=0 → HI=0x12345678 next cycle, and mdu_out=0x12345678 with mdu_op=MFHI.
- div B=0 with HI=0xAA, LO=0xBB preloaded → busy high for 10 cycles, then HI=0xAA, LO=0xBB.
- multu started, then a second start mid-RUN with different operands → second op ignored; only the first result is written at the original completion cycle.
- reset pulsed in cycle 3 of a div → busy=0, HI=LO=0 immediately; no write occurs at the would-be completion cycle.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: operation encodings,
// sequencer states and default latencies.
package mdu_pkg;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  typedef enum logic [3:0] {
    MDU_NONE = 4'd0,
    MULT     = 4'd1,
    MULTU    = 4'd2,
    DIV      = 4'd3,
    DIVU     = 4'd4,
    MFHI     = 4'd5,
    MFLO     = 4'd6,
    MTHI     = 4'd7,
    MTLO     = 4'd8
  } mdu_op_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } mdu_state_e;

endpackage

// File: rtl/mdu_arith.sv
// Combinational MIPS multiply/divide datapath producing the {hi,lo} result
// for one operation; the sequencer only decides when to commit it.
module mdu_arith
  import mdu_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [3:0]  op,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        div_zero
);

  logic [63:0] sprod;
  logic [63:0] uprod;
  logic [31:0] a_mag, b_mag, b_mag_safe, b_safe;
  logic [31:0] mag_q, mag_r, uq, ur;
  logic [31:0] sq, sr;

  assign sprod = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
  assign uprod = {32'd0, a} * {32'd0, b};

  // Signed divide works on magnitudes so INT_MIN / -1 wraps to INT_MIN
  // instead of overflowing; a zero divisor is replaced to keep outputs known.
  assign a_mag      = a[31] ? (~a + 32'd1) : a;
  assign b_mag      = b[31] ? (~b + 32'd1) : b;
  assign b_mag_safe = (b_mag == 32'd0) ? 32'd1 : b_mag;
  assign b_safe     = (b == 32'd0) ? 32'd1 : b;
  assign mag_q      = a_mag / b_mag_safe;
  assign mag_r      = a_mag % b_mag_safe;
  assign sq         = (a[31] ^ b[31]) ? (~mag_q + 32'd1) : mag_q;
  assign sr         = a[31] ? (~mag_r + 32'd1) : mag_r;
  assign uq         = a / b_safe;
  assign ur         = a % b_safe;

  always_comb begin
    hi       = 32'd0;
    lo       = 32'd0;
    div_zero = 1'b0;
    case (op)
      MULT:    {hi, lo} = sprod;
      MULTU:   {hi, lo} = uprod;
      DIV: begin
        hi       = sr;
        lo       = sq;
        div_zero = (b == 32'd0);
      end
      DIVU: begin
        hi       = ur;
        lo       = uq;
        div_zero = (b == 32'd0);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mdu_ctrl.sv
// E-stage MDU sequencer: owns HI/LO, latches results at start and commits
// them after a fixed latency, exposing busy to the stall logic.
module mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  mdu_op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        req,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] mdu_out,
  output logic        dbg_state
);

  localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  mdu_state_e       state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [31:0]      hi_q, hi_n, lo_q, lo_n;
  logic [31:0]      temp_hi, temp_hi_n, temp_lo, temp_lo_n;
  logic             temp_dz, temp_dz_n;
  logic [31:0]      res_hi, res_lo;
  logic             res_dz;

  mdu_arith u_arith (
    .a        (A),
    .b        (B),
    .op       (mdu_op),
    .hi       (res_hi),
    .lo       (res_lo),
    .div_zero (res_dz)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      cnt     <= '0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      temp_hi <= 32'd0;
      temp_lo <= 32'd0;
      temp_dz <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      hi_q    <= hi_n;
      lo_q    <= lo_n;
      temp_hi <= temp_hi_n;
      temp_lo <= temp_lo_n;
      temp_dz <= temp_dz_n;
    end
  end

  // Starts arriving while RUN are ignored; req never cancels an in-flight op.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    hi_n      = hi_q;
    lo_n      = lo_q;
    temp_hi_n = temp_hi;
    temp_lo_n = temp_lo;
    temp_dz_n = temp_dz;
    case (state)
      S_IDLE: begin
        if (start && !req) begin
          case (mdu_op)
            MULT, MULTU, DIV, DIVU: begin
              temp_hi_n = res_hi;
              temp_lo_n = res_lo;
              temp_dz_n = res_dz;
              cnt_n     = ((mdu_op == MULT) || (mdu_op == MULTU)) ?
                          CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
              state_n   = S_RUN;
            end
            MTHI:    hi_n = A;
            MTLO:    lo_n = A;
            default: ;
          endcase
        end
      end
      S_RUN: begin
        cnt_n = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          state_n = S_IDLE;
          if (!temp_dz) begin
            hi_n = temp_hi;
            lo_n = temp_lo;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  assign busy      = (state == S_RUN);
  assign dbg_state = state;
  assign HI        = hi_q;
  assign LO        = lo_q;
  assign mdu_out   = (mdu_op == MFHI) ? hi_q : (mdu_op == MFLO) ? lo_q : 32'd0;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: directed vector table, hand-written
// corner sequences and random traffic against a cycle-level reference model.
module tb_mdu_ctrl;
  import mdu_pkg::*;

  localparam int NM = 5;
  localparam int ND = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  mdu_op = 4'd0;
  logic [31:0] A = 32'd0, B = 32'd0;
  logic        req = 1'b0;
  logic        busy, dbg_state;
  logic [31:0] HI, LO, mdu_out;

  int n_cmp = 0;
  int n_fail = 0;

  mdu_ctrl #(.MULT_CYCLES(NM), .DIV_CYCLES(ND)) dut (
    .clk(clk), .reset(reset), .start(start), .mdu_op(mdu_op), .A(A), .B(B),
    .req(req), .busy(busy), .HI(HI), .LO(LO), .mdu_out(mdu_out),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // Reference model: remaining busy cycles plus the pending architectural result.
  int          m_left = 0;
  logic [31:0] m_hi = 0, m_lo = 0, m_phi = 0, m_plo = 0;
  bit          m_pdz = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  task automatic model_edge(input logic s, input logic [3:0] op, input logic [31:0] a, b, input logic r);
    longint sa, sb, q, rm;
    logic [63:0] p;
    if (m_left > 0) begin
      m_left--;
      if (m_left == 0 && !m_pdz) begin
        m_hi = m_phi;
        m_lo = m_plo;
      end
    end else if (s && !r) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      case (op)
        MULT:  begin p = 64'(sa * sb); m_phi = p[63:32]; m_plo = p[31:0]; m_pdz = 0; m_left = NM; end
        MULTU: begin p = 64'(a) * 64'(b); m_phi = p[63:32]; m_plo = p[31:0]; m_pdz = 0; m_left = NM; end
        DIV: begin
          m_pdz = (b == 0); m_left = ND;
          if (b != 0) begin q = sa / sb; rm = sa % sb; m_plo = q[31:0]; m_phi = rm[31:0]; end
        end
        DIVU: begin
          m_pdz = (b == 0); m_left = ND;
          if (b != 0) begin m_plo = a / b; m_phi = a % b; end
        end
        MTHI: m_hi = a;
        MTLO: m_lo = a;
        default: ;
      endcase
    end
  endtask

  // Called at a falling edge: drive, let one rising edge pass, compare at the next falling edge.
  task automatic tick(input logic s, input logic [3:0] op, input logic [31:0] a, b, input logic r);
    logic [31:0] exp_out;
    start = s; mdu_op = op; A = a; B = b; req = r;
    @(posedge clk);
    model_edge(s, op, a, b, r);
    @(negedge clk);
    exp_out = (op == MFHI) ? m_hi : (op == MFLO) ? m_lo : 32'd0;
    check("busy", {31'd0, busy}, {31'd0, m_left > 0});
    check("state", {31'd0, dbg_state}, {31'd0, m_left > 0});
    check("hi", HI, m_hi);
    check("lo", LO, m_lo);
    check("mdu_out", mdu_out, exp_out);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(0, MDU_NONE, 0, 0, 0);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    #1;
    m_left = 0; m_hi = 0; m_lo = 0; m_phi = 0; m_plo = 0; m_pdz = 0;
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_hi", HI, 32'd0);
    check("reset_lo", LO, 32'd0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Issue an op, count busy cycles (bounded), return the count.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, b, output int n);
    int guard;
    tick(1, op, a, b, 0);
    n = 0; guard = 0;
    while (busy === 1'b1 && guard < 40) begin
      n++; guard++;
      tick(0, MDU_NONE, 0, 0, 0);
    end
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a, b, hi, lo;
    int          cyc;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int n;
    vecs[0] = '{MULT,  32'hFFFFFFFE, 32'd3,          32'hFFFFFFFF, 32'hFFFFFFFA, NM};
    vecs[1] = '{DIVU,  32'd100,      32'd7,          32'd2,        32'd14,       ND};
    vecs[2] = '{DIV,   32'hFFFFFFF9, 32'd2,          32'hFFFFFFFF, 32'hFFFFFFFD, ND};
    vecs[3] = '{DIV,   32'h80000000, 32'hFFFFFFFF,   32'd0,        32'h80000000, ND};
    vecs[4] = '{MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF,   32'hFFFFFFFE, 32'h00000001, NM};
    vecs[5] = '{MULT,  32'h80000000, 32'h80000000,   32'h40000000, 32'h00000000, NM};
    vecs[6] = '{DIV,   32'd7,        32'hFFFFFFFE,   32'd1,        32'hFFFFFFFD, ND};
    vecs[7] = '{DIVU,  32'hFFFFFFFF, 32'd2,          32'd1,        32'h7FFFFFFF, ND};

    @(negedge clk);
    pulse_reset();
    check("mdu_out_reset", mdu_out, 32'd0);
    idle(2);

    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, n);
      check($sformatf("vec%0d_cycles", i), 32'(n), 32'(vecs[i].cyc));
      check($sformatf("vec%0d_hi", i), HI, vecs[i].hi);
      check($sformatf("vec%0d_lo", i), LO, vecs[i].lo);
    end

    // mthi blocked by req, then accepted; read back through mfhi.
    tick(1, MTHI, 32'h12345678, 0, 1);
    check("mthi_req_hi", HI, 32'h1);
    tick(1, MTHI, 32'h12345678, 0, 0);
    check("mthi_hi", HI, 32'h12345678);
    tick(0, MFHI, 0, 0, 0);
    check("mfhi_out", mdu_out, 32'h12345678);

    // Divide by zero keeps preloaded HI/LO after the full latency.
    tick(1, MTHI, 32'hAA, 0, 0);
    tick(1, MTLO, 32'hBB, 0, 0);
    run_op(DIV, 32'd55, 32'd0, n);
    check("dz_cycles", 32'(n), 32'(ND));
    check("dz_hi", HI, 32'hAA);
    check("dz_lo", LO, 32'hBB);

    // Second start mid-RUN (and a req) must not disturb the first multu.
    tick(1, MULTU, 32'd6, 32'd7, 0);
    idle(1);
    tick(1, MULTU, 32'd1000, 32'd1000, 0);
    tick(0, MDU_NONE, 0, 0, 1);
    idle(1);
    check("ignore_still_busy", {31'd0, busy}, 32'd1);
    check("ignore_lo_old", LO, 32'hBB);
    idle(1);
    check("ignore_done", {31'd0, busy}, 32'd0);
    check("ignore_lo", LO, 32'd42);
    check("ignore_hi", HI, 32'd0);

    // Back-to-back: new start in the cycle busy falls.
    run_op(MULT, 32'd3, 32'd5, n);
    check("b2b_first", LO, 32'd15);
    run_op(MULT, 32'hFFFFFFFF, 32'd9, n);
    check("b2b_cycles", 32'(n), 32'(NM));
    check("b2b_lo", LO, 32'hFFFFFFF7);

    // Reset in cycle 3 of a div aborts with no completion write.
    tick(1, DIV, 32'd90, 32'd9, 0);
    idle(2);
    pulse_reset();
    idle(ND + 2);
    check("abort_lo", LO, 32'd0);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      logic [31:0] ra, rb;
      ra = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
      rb = ($urandom_range(0, 5) == 0) ? 32'd0 :
           ($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 9)) : $urandom;
      tick(1'($urandom_range(0, 2) != 0), 4'($urandom_range(0, 8)), ra, rb,
           1'($urandom_range(0, 7) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
